// File: rtl/wb_fwd_pipe_pkg.sv
// Shared types for the write-back forwarding pipeline.
// Holds the default register widths, the per-stage entry struct and the
// bubble constant.
package wb_fwd_pipe_pkg;

    // Default widths, matching RegBus / RegAddrBus.
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    // One in-flight write-back slot.
    // rdy=0 marks a load whose data is still on its way.
    typedef struct packed {
        logic                 wreg;
        logic [WB_ADDR_W-1:0] wd;
        logic [WB_DATA_W-1:0] wdata;
        logic                 rdy;
    } wb_entry_t;

    // Empty slot: writes nothing, never forwards, and is never a pending load.
    localparam wb_entry_t BUBBLE = '{wreg: 1'b0, wd: '0, wdata: '0, rdy: 1'b1};

    // Entry as it is stored in a stage.
    // By the time an entry reaches the last stage its data is final.
    function automatic wb_entry_t promote(input wb_entry_t e, input logic last);
        promote = e;
        if (last) begin
            promote.rdy = 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_fwd_mux.sv
// One forwarding read port.
// Picks the first candidate (index 0 = youngest) whose destination matches
// the read address. If nothing matches it falls back to the regfile data.
// r0 and disabled ports always read as zero.
module wb_fwd_mux
    import wb_fwd_pipe_pkg::*;
#(
    parameter int NUM_CAND   = 4,
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_ADDR_W = WB_ADDR_W
) (
    input  logic                  re,
    input  logic [REG_ADDR_W-1:0] addr,
    input  wb_entry_t             cand [NUM_CAND],
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  hit,
    output logic                  not_rdy
);

    // Priority search: scan oldest to youngest so the youngest match is the
    // last assignment and therefore wins.
    always_comb begin
        rdata   = rf_rdata;
        hit     = 1'b0;
        not_rdy = 1'b0;
        if (!re || addr == '0) begin
            rdata = '0;
        end else begin
            for (int c = NUM_CAND - 1; c >= 0; c--) begin
                if (cand[c].wreg && cand[c].wd == addr) begin
                    rdata   = cand[c].wdata;
                    hit     = 1'b1;
                    not_rdy = !cand[c].rdy;
                end
            end
        end
    end

endmodule

// File: rtl/wb_fwd_pipe.sv
// Write-back pipeline with per-stage stall, global flush and operand
// forwarding.
// Stage 0 is nearest ex. Stage DEPTH-1 drives the regfile write port.
// Optional load-hazard detection is enabled by WB_FWD_PIPE_LOAD_HAZARD_EN.
module wb_fwd_pipe
    import wb_fwd_pipe_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_ADDR_W = WB_ADDR_W,
    parameter int DEPTH      = 3,
    parameter int NUM_RD     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_wreg,
    input  logic [REG_ADDR_W-1:0]        in_wd,
    input  logic [DATA_W-1:0]            in_wdata,
    input  logic                         in_rdy,
    input  logic [DEPTH-1:0]             stall_i,
    input  logic                         flush_i,
    output logic                         wb_we,
    output logic [REG_ADDR_W-1:0]        wb_waddr,
    output logic [DATA_W-1:0]            wb_wdata,
    input  logic [NUM_RD-1:0]            rd_re,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0]     rf_rdata,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_hit,
    output logic                         load_stall_o
);

    // The entry struct takes its field widths from the package.
    // Change the widths there, not only through these parameters.
    wb_entry_t       st   [DEPTH];
    wb_entry_t       cand [DEPTH+1];
    wb_entry_t       in_e;
    logic [DEPTH:0]  stall_ext;
    logic [NUM_RD-1:0] port_not_rdy;

    // Bit k of stall_ext is the hold request of the stage feeding stage k.
    // The inputs (bit 0) never stall.
    assign stall_ext = {stall_i, 1'b0};

    // Incoming ex result packaged as an entry.
    // Without hazard tracking every entry counts as final.
    always_comb begin
        in_e.wreg  = in_wreg;
        in_e.wd    = in_wd;
        in_e.wdata = in_wdata;
`ifdef WB_FWD_PIPE_LOAD_HAZARD_EN
        in_e.rdy   = in_rdy;
`else
        in_e.rdy   = 1'b1;
`endif
    end

    // Candidate list, youngest first.
    // cand[k] is also the source that stage k loads from.
    always_comb begin
        cand[0] = in_e;
        for (int k = 0; k < DEPTH; k++) begin
            cand[k+1] = st[k];
        end
    end

    // Stage registers.
    // Priority: reset, flush, own hold, bubble behind a held upstream stage,
    // then advance.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rst) begin
                st[k] <= '0;
            end else if (flush_i) begin
                st[k] <= BUBBLE;
            end else if (stall_ext[k+1]) begin
                st[k] <= st[k];
            end else if (stall_ext[k]) begin
                st[k] <= BUBBLE;
            end else begin
                st[k] <= promote(cand[k], k == DEPTH - 1);
            end
        end
    end

    assign wb_we    = st[DEPTH-1].wreg;
    assign wb_waddr = st[DEPTH-1].wd;
    assign wb_wdata = st[DEPTH-1].wdata;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        wb_fwd_mux #(
            .NUM_CAND   (DEPTH + 1),
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_mux (
            .re       (rd_re[i]),
            .addr     (rd_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .cand     (cand),
            .rf_rdata (rf_rdata[i*DATA_W +: DATA_W]),
            .rdata    (rd_data[i*DATA_W +: DATA_W]),
            .hit      (rd_hit[i]),
            .not_rdy  (port_not_rdy[i])
        );
    end

`ifdef WB_FWD_PIPE_LOAD_HAZARD_EN
    assign load_stall_o = |port_not_rdy;
`else
    logic unused_rdy;
    assign unused_rdy   = in_rdy ^ (^port_not_rdy);
    assign load_stall_o = 1'b0;
`endif

endmodule
